// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the unified memory arbiter, its two requesters
// (instruction fetch and data) and the single-port memory behind it.
// slave  : the arbiter's view (takes requests, drives grants and memory strobes)
// master : the environment's view (requesters plus memory model)
interface unified_mem_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
);
    // fetch port
    logic                 if_req;
    logic [ADDR_SIZE-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_valid;
    logic [DATA_SIZE-1:0] if_rdata;
    // data port
    logic                 d_req;
    logic                 d_we;
    logic [ADDR_SIZE-1:0] d_addr;
    logic [DATA_SIZE-1:0] d_wdata;
    logic                 d_gnt;
    logic                 d_valid;
    logic [DATA_SIZE-1:0] d_rdata;
    // memory side
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;
    // pipeline freeze
    logic                 stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port memory between an
// instruction-fetch port and a data port. Grants are combinational in IDLE,
// the data port normally wins, and the fetch port is forced through after
// STARVE_MAX consecutive denials. A granted read returns its data LATENCY
// cycles later; the memory is released in the valid cycle so a new grant can
// overlap the returning data. CLEAR aborts an outstanding read at the next edge.
// The interface instance must carry the same DATA_SIZE/ADDR_SIZE as the module.
module unified_mem_arbiter #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 10,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CLEAR,
    unified_mem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // starvation counter must hold STARVE_MAX itself
    localparam int              SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [2:0]      LAT_LOAD   = 3'(LATENCY);

    state_t            state_r;
    state_t            state_nxt_s;
    owner_t            owner_r;
    owner_t            owner_nxt_s;
    logic [2:0]        lat_cnt_r;
    logic [2:0]        lat_nxt_s;
    logic [SC_W-1:0]   starve_cnt_r;
    logic [SC_W-1:0]   starve_nxt_s;

    logic              grant_ok_s;
    logic              starve_hit_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic              rd_start_s;
    logic              rd_done_s;

    // grants are only possible out of reset, outside an abort and with the memory free
    assign grant_ok_s   = RESET_N & ~CLEAR & (state_r == ST_IDLE);
    assign starve_hit_s = (starve_cnt_r == STARVE_LIM);
    assign rd_start_s   = if_gnt_s | (d_gnt_s & ~bus.d_we);
    // read data is due in the cycle where the latency counter reaches one
    assign rd_done_s    = (lat_cnt_r == 3'd1) && (owner_r != OWN_NONE);

    // arbitration: data first unless the fetch port has been denied STARVE_MAX times
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!grant_ok_s) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (bus.d_req && !(bus.if_req && starve_hit_s)) begin
            d_gnt_s  = 1'b1;
        end else if (bus.if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // next state, read owner and latency countdown
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        lat_nxt_s   = lat_cnt_r;
        if (CLEAR) begin
            state_nxt_s = ST_IDLE;
            owner_nxt_s = OWN_NONE;
            lat_nxt_s   = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_start_s) begin
                        owner_nxt_s = if_gnt_s ? OWN_IF : OWN_D;
                        lat_nxt_s   = LAT_LOAD;
                        state_nxt_s = (LATENCY > 1) ? ST_WAIT : ST_IDLE;
                    end else if (lat_cnt_r != 3'd0) begin
                        lat_nxt_s   = lat_cnt_r - 3'd1;
                        owner_nxt_s = (lat_cnt_r == 3'd1) ? OWN_NONE : owner_r;
                    end else begin
                        owner_nxt_s = OWN_NONE;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r != 3'd0) begin
                        lat_nxt_s = lat_cnt_r - 3'd1;
                    end else begin
                        lat_nxt_s = 3'd0;
                    end
                    // leave one cycle early so the valid cycle is already IDLE
                    if (lat_cnt_r <= 3'd2) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    owner_nxt_s = OWN_NONE;
                    lat_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // starvation count: consecutive cycles the fetch port waited behind a data grant
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (CLEAR) begin
            starve_nxt_s = {SC_W{1'b0}};
        end else if (!bus.if_req || if_gnt_s) begin
            starve_nxt_s = {SC_W{1'b0}};
        end else if (d_gnt_s && (starve_cnt_r < STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // state registers, cleared asynchronously by RESET_N
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            lat_cnt_r    <= 3'd0;
            starve_cnt_r <= {SC_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            lat_cnt_r    <= lat_nxt_s;
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // memory strobes steered from the granted port; everything forced low in reset
    always_comb begin
        bus.if_gnt    = if_gnt_s;
        bus.d_gnt     = d_gnt_s;
        bus.mem_en    = if_gnt_s | d_gnt_s;
        bus.mem_we    = d_gnt_s & bus.d_we;
        bus.mem_addr  = {ADDR_SIZE{1'b0}};
        bus.mem_wdata = {DATA_SIZE{1'b0}};
        if (if_gnt_s) begin
            bus.mem_addr = bus.if_addr;
        end else if (d_gnt_s) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.mem_wdata = {DATA_SIZE{1'b0}};
            end
        end else begin
            bus.mem_addr  = {ADDR_SIZE{1'b0}};
            bus.mem_wdata = {DATA_SIZE{1'b0}};
        end
    end

    // read return: only the owner sees valid and data, the other rdata stays zero
    always_comb begin
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;
        bus.if_rdata = {DATA_SIZE{1'b0}};
        bus.d_rdata  = {DATA_SIZE{1'b0}};
        if (RESET_N && rd_done_s && (owner_r == OWN_IF)) begin
            bus.if_valid = 1'b1;
            bus.if_rdata = bus.mem_rdata;
        end else if (RESET_N && rd_done_s && (owner_r == OWN_D)) begin
            bus.d_valid  = 1'b1;
            bus.d_rdata  = bus.mem_rdata;
        end else begin
            bus.if_valid = 1'b0;
            bus.d_valid  = 1'b0;
        end
    end

    // freeze while a request is waiting or a read is outstanding
    always_comb begin
        bus.stall = 1'b0;
        if (RESET_N) begin
            bus.stall = (bus.if_req & ~if_gnt_s) | (bus.d_req & ~d_gnt_s) | (state_r == ST_WAIT);
        end else begin
            bus.stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. Two instances: LATENCY=2 (main
// scenarios) and LATENCY=1 (back-to-back fetch). Stimulus pushes expected read
// returns into per-port queues; monitors pop and compare on every valid pulse.
module tb_unified_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic CLK = 1'b0;
    logic RESET_N;
    logic CLEAR;

    always #5 CLK = ~CLK;

    unified_mem_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) busa ();
    unified_mem_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) busb ();

    unified_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .LATENCY(2), .STARVE_MAX(3)) ua (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .bus(busa)
    );

    unified_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .LATENCY(1), .STARVE_MAX(3)) ub (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .bus(busb)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t qa_if[$];
    exp_t qa_d[$];
    exp_t qb_if[$];
    exp_t qb_d[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0;

    always @(posedge CLK) cyc <= cyc + 1;

    // memory content is a fixed function of the address
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {6'd0, a, 6'd0, a};
    endfunction

    // memory models: address pipeline of depth LATENCY, data out at the far end
    logic [AW-1:0] pa0 = '0;
    logic [AW-1:0] pa1 = '0;
    logic [AW-1:0] pb0 = '0;
    always @(posedge CLK) begin
        pa0 <= busa.mem_addr;
        pa1 <= pa0;
        pb0 <= busb.mem_addr;
    end
    assign busa.mem_rdata = mem_f(pa1);
    assign busb.mem_rdata = mem_f(pb0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got_valid(input string name, input logic [DW-1:0] rdata,
                             input logic [DW-1:0] other, input bit have, input exp_t e);
        if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got valid with rdata %0h at cycle %0d, expected no valid", name, rdata, cyc);
        end else begin
            chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            chk({name, "_rdata"}, 64'(rdata), 64'(e.data));
            chk({name, "_other_rdata"}, 64'(other), 64'd0);
        end
    endtask

    exp_t e_aif, e_ad, e_bif, e_bd;
    bit   h_aif, h_ad, h_bif, h_bd;

    // scoreboard monitors: every valid pulse consumes one expected entry
    always @(negedge CLK) begin
        if (busa.if_valid) begin
            h_aif = (qa_if.size() > 0);
            if (h_aif) e_aif = qa_if.pop_front();
            got_valid("a_if_valid", busa.if_rdata, busa.d_rdata, h_aif, e_aif);
        end
        if (busa.d_valid) begin
            h_ad = (qa_d.size() > 0);
            if (h_ad) e_ad = qa_d.pop_front();
            got_valid("a_d_valid", busa.d_rdata, busa.if_rdata, h_ad, e_ad);
        end
        if (busb.if_valid) begin
            h_bif = (qb_if.size() > 0);
            if (h_bif) e_bif = qb_if.pop_front();
            got_valid("b_if_valid", busb.if_rdata, busb.d_rdata, h_bif, e_bif);
        end
        if (busb.d_valid) begin
            h_bd = (qb_d.size() > 0);
            if (h_bd) e_bd = qb_d.pop_front();
            got_valid("b_d_valid", busb.d_rdata, busb.if_rdata, h_bd, e_bd);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drain(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic idle_inputs();
        busa.if_req = 1'b0; busa.if_addr = '0; busa.d_req = 1'b0; busa.d_we = 1'b0;
        busa.d_addr = '0; busa.d_wdata = '0;
        busb.if_req = 1'b0; busb.if_addr = '0; busb.d_req = 1'b0; busb.d_we = 1'b0;
        busb.d_addr = '0; busb.d_wdata = '0;
    endtask

    task automatic reset_zero_check(input string tag);
        chk({tag, "_ctrl"}, 64'({busa.if_gnt, busa.if_valid, busa.d_gnt, busa.d_valid,
                                 busa.mem_en, busa.mem_we, busa.stall}), 64'd0);
        chk({tag, "_rdata"}, 64'(busa.if_rdata | busa.d_rdata), 64'd0);
        chk({tag, "_mem_addr"}, 64'(busa.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(busa.mem_wdata), 64'd0);
    endtask

    initial begin
        RESET_N = 1'b0;
        CLEAR   = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        // requests during reset must not leak through
        busa.if_req = 1'b1; busa.if_addr = 10'h3FF; busa.d_req = 1'b1; busa.d_addr = 10'h155;
        sample();
        reset_zero_check("por");
        next_cycle();
        idle_inputs();
        RESET_N = 1'b1;

        // single fetch read, LATENCY 2
        next_cycle();
        busa.if_req = 1'b1; busa.if_addr = 10'h004;
        sample();
        chk("t1_if_gnt", 64'(busa.if_gnt), 64'd1);
        chk("t1_d_gnt", 64'(busa.d_gnt), 64'd0);
        chk("t1_mem_en", 64'(busa.mem_en), 64'd1);
        chk("t1_mem_we", 64'(busa.mem_we), 64'd0);
        chk("t1_mem_addr", 64'(busa.mem_addr), 64'h004);
        chk("t1_stall_t", 64'(busa.stall), 64'd0);
        qa_if.push_back('{cyc: cyc + 2, data: mem_f(10'h004)});
        next_cycle();
        busa.if_req = 1'b0;
        sample();
        chk("t1_stall_t1", 64'(busa.stall), 64'd1);
        chk("t1_mem_en_t1", 64'(busa.mem_en), 64'd0);
        next_cycle();
        sample();
        chk("t1_stall_t2", 64'(busa.stall), 64'd0);
        drain(2);

        // simultaneous requests: data wins, fetch follows when memory frees
        next_cycle();
        busa.if_req = 1'b1; busa.if_addr = 10'h010;
        busa.d_req = 1'b1; busa.d_we = 1'b0; busa.d_addr = 10'h020;
        sample();
        chk("t2_d_gnt", 64'(busa.d_gnt), 64'd1);
        chk("t2_if_gnt", 64'(busa.if_gnt), 64'd0);
        chk("t2_mem_addr", 64'(busa.mem_addr), 64'h020);
        qa_d.push_back('{cyc: cyc + 2, data: mem_f(10'h020)});
        next_cycle();
        busa.d_req = 1'b0;
        sample();
        chk("t2_if_gnt_t1", 64'(busa.if_gnt), 64'd0);
        chk("t2_stall_t1", 64'(busa.stall), 64'd1);
        next_cycle();
        sample();
        chk("t2_if_gnt_t2", 64'(busa.if_gnt), 64'd1);
        chk("t2_mem_addr_t2", 64'(busa.mem_addr), 64'h010);
        qa_if.push_back('{cyc: cyc + 2, data: mem_f(10'h010)});
        next_cycle();
        busa.if_req = 1'b0;
        drain(3);

        // starvation: writes held against a waiting fetch
        next_cycle();
        busa.d_req = 1'b1; busa.d_we = 1'b1; busa.d_addr = 10'h033; busa.d_wdata = 32'h1234_5678;
        busa.if_req = 1'b1; busa.if_addr = 10'h044;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t3_d_gnt", 64'(busa.d_gnt), 64'd1);
            chk("t3_if_gnt", 64'(busa.if_gnt), 64'd0);
            chk("t3_mem_we", 64'(busa.mem_we), 64'd1);
            chk("t3_mem_wdata", 64'(busa.mem_wdata), 64'h1234_5678);
            chk("t3_mem_addr", 64'(busa.mem_addr), 64'h033);
            chk("t3_starve_cnt", 64'(ua.starve_cnt_r), 64'(k));
            next_cycle();
        end
        sample();
        chk("t3_if_gnt_forced", 64'(busa.if_gnt), 64'd1);
        chk("t3_d_gnt_denied", 64'(busa.d_gnt), 64'd0);
        chk("t3_mem_addr_f", 64'(busa.mem_addr), 64'h044);
        chk("t3_starve_sat", 64'(ua.starve_cnt_r), 64'd3);
        qa_if.push_back('{cyc: cyc + 2, data: mem_f(10'h044)});
        next_cycle();
        busa.if_req = 1'b0; busa.d_req = 1'b0; busa.d_we = 1'b0; busa.d_wdata = '0;
        sample();
        chk("t3_starve_clr", 64'(ua.starve_cnt_r), 64'd0);
        drain(3);

        // CLEAR aborts an outstanding read
        next_cycle();
        busa.d_req = 1'b1; busa.d_we = 1'b0; busa.d_addr = 10'h055;
        sample();
        chk("t4_d_gnt", 64'(busa.d_gnt), 64'd1);
        next_cycle();
        busa.d_req = 1'b0; CLEAR = 1'b1;
        sample();
        chk("t4_stall_wait", 64'(busa.stall), 64'd1);
        next_cycle();
        CLEAR = 1'b0; busa.if_req = 1'b1; busa.if_addr = 10'h066;
        sample();
        chk("t4_if_gnt_after_clr", 64'(busa.if_gnt), 64'd1);
        chk("t4_stall_idle", 64'(busa.stall), 64'd0);
        chk("t4_d_valid_dropped", 64'(busa.d_valid), 64'd0);
        qa_if.push_back('{cyc: cyc + 2, data: mem_f(10'h066)});
        next_cycle();
        busa.if_req = 1'b0;
        drain(3);
        // no grant while CLEAR is high
        CLEAR = 1'b1; busa.if_req = 1'b1; busa.if_addr = 10'h0AA;
        sample();
        chk("t4_clr_no_gnt", 64'(busa.if_gnt), 64'd0);
        chk("t4_clr_no_en", 64'(busa.mem_en), 64'd0);
        chk("t4_clr_stall", 64'(busa.stall), 64'd1);
        next_cycle();
        CLEAR = 1'b0; busa.if_req = 1'b0;
        drain(1);

        // reset in the middle of WAIT
        busa.if_req = 1'b1; busa.if_addr = 10'h077;
        sample();
        chk("t5_if_gnt", 64'(busa.if_gnt), 64'd1);
        next_cycle();
        #2;
        RESET_N = 1'b0;
        #1;
        reset_zero_check("t5_rst_now");
        next_cycle();
        sample();
        reset_zero_check("t5_rst_t2");
        next_cycle();
        RESET_N = 1'b1; busa.if_req = 1'b0;
        sample();
        chk("t5_no_stale_valid", 64'(busa.if_valid), 64'd0);
        next_cycle();
        busa.if_req = 1'b1; busa.if_addr = 10'h088;
        sample();
        chk("t5_if_gnt_post", 64'(busa.if_gnt), 64'd1);
        chk("t5_mem_addr_post", 64'(busa.mem_addr), 64'h088);
        chk("t5_stall_post", 64'(busa.stall), 64'd0);
        qa_if.push_back('{cyc: cyc + 2, data: mem_f(10'h088)});
        next_cycle();
        busa.if_req = 1'b0;
        drain(3);

        // LATENCY 1: back-to-back fetch reads
        busb.if_req = 1'b1;
        t0 = 0;
        for (int k = 0; k < 6; k++) begin
            busb.if_addr = AW'(10'h100 + k);
            sample();
            chk("t6_if_gnt", 64'(busb.if_gnt), 64'd1);
            chk("t6_stall", 64'(busb.stall), 64'd0);
            chk("t6_mem_addr", 64'(busb.mem_addr), 64'(10'h100 + k));
            qb_if.push_back('{cyc: cyc + 1, data: mem_f(AW'(10'h100 + k))});
            next_cycle();
        end
        busb.if_req = 1'b0;
        sample();
        chk("t6_stall_end", 64'(busb.stall), 64'd0);
        drain(3);

        chk("qa_if_empty", 64'(qa_if.size()), 64'd0);
        chk("qa_d_empty", 64'(qa_d.size()), 64'd0);
        chk("qb_if_empty", 64'(qb_if.size()), 64'd0);
        chk("qb_d_empty", 64'(qb_d.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // guard against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
